pe_loader: RTL and testbench
============================

Name: pe_loader

Overview:
- Upstream feeder for one PE; drives that PE's instruction-load and data-load inputs.
- Per job:
  - Accepts a programmable number of instruction words over a valid/ready stream and forwards them to the PE.
  - Buffers exactly REG_NUM complex data words in an internal FIFO.
  - Releases the data as one gap-free burst of REG_NUM consecutive din_v cycles, so the PE's shift-register load completes without bubbles.

Parameters:
- DATA_WIDTH, 16, width of one real/imag component; data word is DATA_WIDTH*2.
- INST_WIDTH, 64, instruction word width.
- REG_NUM, 32, data words per job; PE shift-register depth; FIFO depth.
- REG_ADDR_WIDTH, 5, log2(REG_NUM).
- INST_NUM, 16, max instructions per job.
- INST_CNT_WIDTH, 5, width of inst_len; holds 0..INST_NUM.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- start  in  1  job start pulse; sampled in IDLE only.
- inst_len  in  INST_CNT_WIDTH  instruction count for the job, latched at start.
- s_inst_v  in  1  upstream instruction valid.
- s_inst_rdy  out  1  instruction ready.
- s_inst  in  INST_WIDTH  upstream instruction word.
- s_data_v  in  1  upstream data valid.
- s_data_rdy  out  1  data ready.
- s_data  in  DATA_WIDTH*2  upstream complex word {imag, real}.
- inst_in_v  out  1  instruction valid to PE.
- inst_in  out  INST_WIDTH  instruction to PE.
- din_v  out  1  data valid to PE.
- din_pe  out  DATA_WIDTH*2  data to PE.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse on the final din_v beat.

Behaviour:
- Reset (rst low, async): state IDLE, FIFO empty, all counters 0.
  - Outputs s_inst_rdy, s_data_rdy, inst_in_v, din_v, busy, done = 0.
  - Outputs inst_in, din_pe = 0.
- States: IDLE, INST, WAIT, BURST.
- IDLE:
  - Both rdy outputs low.
  - start=1: latch inst_len (values above INST_NUM saturate to INST_NUM).
  - Enter INST if latched len>0, else WAIT. busy=1 from the next cycle.
- INST:
  - s_inst_rdy=1.
  - Each s_inst_v&&s_inst_rdy handshake registers s_inst to inst_in with inst_in_v=1 on the following cycle (latency 1); otherwise inst_in_v=0 and inst_in holds its value.
  - The handshake that makes the count equal len moves the FSM to WAIT.
- Data acceptance, INST and WAIT only:
  - s_data_rdy = busy && (fifo_count < REG_NUM) && state!=BURST.
  - Data may arrive concurrently with instructions.
  - Accepted words are written to the FIFO in arrival order.
- WAIT:
  - Move to BURST when fifo_count==REG_NUM and the last inst_in_v beat has been issued.
  - A simultaneous write of the final word and the transition is allowed; the count is evaluated after the write.
- BURST:
  - Pop one word per cycle for exactly REG_NUM consecutive cycles.
  - din_pe is registered from the FIFO head, with din_v=1 each of those cycles.
  - The first beat appears 1 cycle after BURST entry.
  - done=1 coincident with the REG_NUM-th din_v beat.
  - Next cycle: state IDLE, busy=0, FIFO empty.
- Inputs ignored:
  - start while busy.
  - s_inst_v/s_data_v while the corresponding rdy is low.
- Never emitted: inst_in_v and din_v are never high in the same cycle.
- Counters:
  - Instruction counter wraps only via reset to 0 at job end.
  - FIFO pointers are REG_ADDR_WIDTH bits and wrap modulo REG_NUM.
  - fifo_count is REG_ADDR_WIDTH+1 bits.
- Reset mid-job: immediate abort. FIFO contents discarded; no done pulse.

Decomposition:
- Shared header parameters.vh: DATA_WIDTH, INST_WIDTH, REG_NUM, REG_ADDR_WIDTH, INST_NUM.
- State encodings are local to the module.
- One sub-module: sync_fifo.
  - Parameterised width/depth, push/pop, count, full/empty, async active-low rst.
  - Reusable for the downstream PE output collector.

Test Plan:
- inst_len=3, 3 instruction words 0xA..0xC, then 32 data words 1..32 all back-to-back -> inst_in_v pulses carry A,B,C one cycle after each handshake; din_v high 32 consecutive cycles carrying 1..32; done on word 32; busy low the next cycle.
- inst_len=0, 32 data words with s_data_v toggling every other cycle -> no inst_in_v; din_v burst still 32 contiguous cycles, starting only after the 32nd word is accepted.
- 33rd data word presented and start re-pulsed mid-job -> s_data_rdy=0 when FIFO holds 32; 33rd word not consumed; second start ignored; busy remains 1.
- Data completes before instructions (inst_len=4, 32 words first, then instructions) -> state stays WAIT; burst begins only after the 4th inst_in_v beat; no din_v overlaps inst_in_v.
- rst asserted during BURST after 10 beats -> all outputs 0 asynchronously; after release a new job with fresh data 100..131 outputs exactly 100..131, with no stale words.
- inst_len=20 (above INST_NUM) -> exactly 16 instructions accepted before the FSM leaves INST.

Source files
------------

// File: rtl/pe_loader_pkg.sv
// Shared sizing for the PE loader and its FIFO, plus the instruction-length clamp.
package pe_loader_pkg;

  localparam int DATA_WIDTH     = 16;
  localparam int INST_WIDTH     = 64;
  localparam int REG_NUM        = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int INST_NUM       = 16;
  localparam int INST_CNT_WIDTH = 5;

  // Requested lengths above what one PE can hold are clamped to INST_NUM.
  function automatic logic [INST_CNT_WIDTH-1:0] sat_inst_len(input logic [INST_CNT_WIDTH-1:0] len);
    if (len > INST_CNT_WIDTH'(INST_NUM)) begin
      return INST_CNT_WIDTH'(INST_NUM);
    end
    return len;
  endfunction

endpackage

// File: rtl/pe_loader_if.sv
// Upstream instruction/data streams and the PE-facing load bus of one PE loader.
interface pe_loader_if;
  import pe_loader_pkg::*;

  logic                      s_inst_v;
  logic                      s_inst_rdy;
  logic [INST_WIDTH-1:0]     s_inst;
  logic                      s_data_v;
  logic                      s_data_rdy;
  logic [DATA_WIDTH*2-1:0]   s_data;
  logic                      inst_in_v;
  logic [INST_WIDTH-1:0]     inst_in;
  logic                      din_v;
  logic [DATA_WIDTH*2-1:0]   din_pe;

  // Upstream feeder / PE observer side.
  modport master (
    output s_inst_v, s_inst, s_data_v, s_data,
    input  s_inst_rdy, s_data_rdy, inst_in_v, inst_in, din_v, din_pe
  );

  // Loader side.
  modport slave (
    input  s_inst_v, s_inst, s_data_v, s_data,
    output s_inst_rdy, s_data_rdy, inst_in_v, inst_in, din_v, din_pe
  );

endinterface

// File: rtl/pe_loader_sync_fifo.sv
// Single-clock FIFO with occupancy count; DEPTH must equal 2**ADDR_W so the
// pointers wrap naturally. Pushes when full and pops when empty are dropped.
module sync_fifo #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [WIDTH-1:0]  push_data,
  input  logic              pop,
  output logic [WIDTH-1:0]  pop_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              do_push;
  logic              do_pop;

  assign full     = (count_q == (ADDR_W+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign count    = count_q;
  assign pop_data = mem[rd_ptr_q];

  // Advance pointers and occupancy for the accepted push/pop of this cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers; reset empties the FIFO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since the count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/pe_loader.sv
// Feeds one PE: forwards a job's instructions, buffers REG_NUM data words,
// then releases them as one bubble-free burst so the PE shift load is contiguous.
module pe_loader
  import pe_loader_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [INST_CNT_WIDTH-1:0] inst_len,
  pe_loader_if.slave                bus,
  output logic                      busy,
  output logic                      done
);

  typedef enum logic [1:0] {ST_IDLE, ST_INST, ST_WAIT, ST_BURST} state_t;

  localparam logic [REG_ADDR_WIDTH:0] FIFO_FULL = (REG_ADDR_WIDTH+1)'(REG_NUM);
  localparam logic [REG_ADDR_WIDTH:0] LAST_POP  = (REG_ADDR_WIDTH+1)'(REG_NUM - 1);

  state_t                      state_q, state_d;
  logic [INST_CNT_WIDTH-1:0]   len_q, len_d;
  logic [INST_CNT_WIDTH-1:0]   inst_cnt_q, inst_cnt_d;
  logic [REG_ADDR_WIDTH:0]     burst_cnt_q, burst_cnt_d;
  logic [INST_WIDTH-1:0]       inst_in_q, inst_in_d;
  logic                        inst_in_v_q, inst_in_v_d;
  logic [DATA_WIDTH*2-1:0]     din_q, din_d;
  logic                        din_v_q, din_v_d;
  logic                        done_q, done_d;

  logic                        inst_rdy;
  logic                        data_rdy;
  logic                        inst_hs;
  logic                        fifo_push;
  logic                        fifo_pop;
  logic [DATA_WIDTH*2-1:0]     fifo_head;
  logic [REG_ADDR_WIDTH:0]     fifo_count;
  logic [REG_ADDR_WIDTH:0]     count_after;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [INST_CNT_WIDTH-1:0]   start_len;

  assign busy        = (state_q != ST_IDLE);
  assign inst_rdy    = (state_q == ST_INST);
  assign data_rdy    = busy && !fifo_full && (state_q != ST_BURST);
  assign inst_hs     = bus.s_inst_v && inst_rdy;
  assign fifo_push   = bus.s_data_v && data_rdy;
  assign fifo_pop    = (state_q == ST_BURST) && (burst_cnt_q < FIFO_FULL) && !fifo_empty;
  assign count_after = fifo_count + {{REG_ADDR_WIDTH{1'b0}}, fifo_push};
  assign start_len   = sat_inst_len(inst_len);

  assign bus.s_inst_rdy = inst_rdy;
  assign bus.s_data_rdy = data_rdy;
  assign bus.inst_in_v  = inst_in_v_q;
  assign bus.inst_in    = inst_in_q;
  assign bus.din_v      = din_v_q;
  assign bus.din_pe     = din_q;
  assign done           = done_q;

  sync_fifo #(
    .WIDTH  (DATA_WIDTH*2),
    .DEPTH  (REG_NUM),
    .ADDR_W (REG_ADDR_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (bus.s_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Job sequencing: instruction forwarding, wait-for-full, then the data burst.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    inst_cnt_d  = inst_cnt_q;
    burst_cnt_d = burst_cnt_q;
    inst_in_d   = inst_in_q;
    inst_in_v_d = 1'b0;
    din_d       = din_q;
    din_v_d     = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d   = start_len;
          state_d = (start_len != '0) ? ST_INST : ST_WAIT;
        end
      end
      ST_INST: begin
        if (inst_hs) begin
          inst_in_d   = bus.s_inst;
          inst_in_v_d = 1'b1;
          inst_cnt_d  = inst_cnt_q + INST_CNT_WIDTH'(1);
          if (inst_cnt_d == len_q) state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // The last instruction beat is already on the wire in the first WAIT
        // cycle, so only the FIFO level (including this cycle's write) gates entry.
        if (count_after == FIFO_FULL) state_d = ST_BURST;
      end
      ST_BURST: begin
        if (fifo_pop) begin
          din_d       = fifo_head;
          din_v_d     = 1'b1;
          burst_cnt_d = burst_cnt_q + (REG_ADDR_WIDTH+1)'(1);
          if (burst_cnt_q == LAST_POP) done_d = 1'b1;
        end
        if (done_q) begin
          state_d     = ST_IDLE;
          len_d       = '0;
          inst_cnt_d  = '0;
          burst_cnt_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset aborts any job in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      inst_cnt_q  <= '0;
      burst_cnt_q <= '0;
      inst_in_q   <= '0;
      inst_in_v_q <= 1'b0;
      din_q       <= '0;
      din_v_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      inst_cnt_q  <= inst_cnt_d;
      burst_cnt_q <= burst_cnt_d;
      inst_in_q   <= inst_in_d;
      inst_in_v_q <= inst_in_v_d;
      din_q       <= din_d;
      din_v_q     <= din_v_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_pe_loader.sv
// Scoreboard bench for pe_loader: driven handshakes push expected words,
// a monitor collects PE-side beats, and each scenario compares the two.
module tb_pe_loader;
  import pe_loader_pkg::*;

  logic                      clk;
  logic                      rst;
  logic                      start;
  logic [INST_CNT_WIDTH-1:0] inst_len;
  logic                      busy;
  logic                      done;

  pe_loader_if bus ();

  pe_loader dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .inst_len (inst_len),
    .bus      (bus.slave),
    .busy     (busy),
    .done     (done)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int overlap_cnt = 0;
  int last_data_hs = 0;
  int last_inst_hs = 0;

  logic [INST_WIDTH-1:0]   inst_exp [$];
  logic [INST_WIDTH-1:0]   inst_obs [$];
  int                      inst_hs_cyc [$];
  int                      inst_obs_cyc [$];
  logic [DATA_WIDTH*2-1:0] data_exp [$];
  logic [DATA_WIDTH*2-1:0] data_obs [$];
  int                      din_cyc [$];
  int                      done_cyc [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: samples PE-side outputs 1 ns after each rising edge.
  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (rst) begin
      if (bus.inst_in_v) begin
        inst_obs.push_back(bus.inst_in);
        inst_obs_cyc.push_back(cyc);
      end
      if (bus.din_v) begin
        data_obs.push_back(bus.din_pe);
        din_cyc.push_back(cyc);
      end
      if (bus.inst_in_v && bus.din_v) overlap_cnt = overlap_cnt + 1;
      if (done) done_cyc.push_back(cyc);
    end
  end

  task automatic clear_sb();
    inst_exp.delete(); inst_obs.delete(); inst_hs_cyc.delete(); inst_obs_cyc.delete();
    data_exp.delete(); data_obs.delete(); din_cyc.delete(); done_cyc.delete();
    overlap_cnt = 0;
  endtask

  // order: 0 concurrent, 1 instructions before data, 2 data before instructions.
  task automatic drive_job(input bit do_start, input logic [INST_CNT_WIDTH-1:0] len,
                           input int n_inst, input int n_data,
                           input logic [INST_WIDTH-1:0] ibase, input logic [DATA_WIDTH*2-1:0] dbase,
                           input int order, input bit toggle, input int max_cyc,
                           output int n_inst_acc, output int n_data_acc);
    int ii;
    int di;
    ii = 0;
    di = 0;
    if (do_start) begin
      @(negedge clk);
      start = 1'b1;
      inst_len = len;
      @(negedge clk);
      start = 1'b0;
    end
    for (int c = 0; c < max_cyc && (ii < n_inst || di < n_data); c++) begin
      bus.s_inst_v = (ii < n_inst) && (order != 2 || di >= n_data);
      bus.s_inst   = ibase + INST_WIDTH'(ii);
      bus.s_data_v = (di < n_data) && (order != 1 || ii >= n_inst) && (!toggle || (c % 2 == 0));
      bus.s_data   = dbase + (DATA_WIDTH*2)'(di);
      if (bus.s_inst_v && bus.s_inst_rdy) begin
        inst_exp.push_back(bus.s_inst);
        inst_hs_cyc.push_back(cyc + 1);
        last_inst_hs = cyc + 1;
        ii++;
      end
      if (bus.s_data_v && bus.s_data_rdy) begin
        data_exp.push_back(bus.s_data);
        last_data_hs = cyc + 1;
        di++;
      end
      @(negedge clk);
    end
    bus.s_inst_v = 1'b0;
    bus.s_data_v = 1'b0;
    n_inst_acc = ii;
    n_data_acc = di;
  endtask

  task automatic wait_done(input int max_cyc, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      if (done_cyc.size() > 0) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; inst_len = '0;
    bus.s_inst_v = 1'b0; bus.s_inst = '0; bus.s_data_v = 1'b0; bus.s_data = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, bus.s_inst_rdy, bus.s_data_rdy, bus.inst_in_v, bus.din_v} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl got=%b want=000000",
               {busy, done, bus.s_inst_rdy, bus.s_data_rdy, bus.inst_in_v, bus.din_v});
    end
    checks++;
    if (bus.inst_in !== '0 || bus.din_pe !== '0) begin
      errors++;
      $display("[TB] FAIL reset_data got=%h/%h want=0/0", bus.inst_in, bus.din_pe);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || bus.s_data_rdy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_after_reset got=%b%b want=00", busy, bus.s_data_rdy);
    end
  endtask

  task automatic test_basic();
    int ni, nd, first_din;
    bit seen;
    clear_sb();
    drive_job(1'b1, 5'd3, 3, 32, 64'hA, 32'd1, 1, 1'b0, 100, ni, nd);
    wait_done(100, seen);
    checks++;
    if (!seen || ni != 3 || nd != 32) begin
      errors++;
      $display("[TB] FAIL basic_accept got=done%0d inst%0d data%0d want=done1 inst3 data32", seen, ni, nd);
    end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy_on_done got=%b want=1", busy); end
    checks++;
    if (inst_obs.size() != 3) begin errors++; $display("[TB] FAIL basic_inst_cnt got=%0d want=3", inst_obs.size()); end
    while (inst_exp.size() > 0 && inst_obs.size() > 0) begin
      logic [INST_WIDTH-1:0] e, o;
      int ec, oc;
      e = inst_exp.pop_front(); o = inst_obs.pop_front();
      ec = inst_hs_cyc.pop_front(); oc = inst_obs_cyc.pop_front();
      checks++;
      if (o !== e || oc != ec) begin
        errors++;
        $display("[TB] FAIL basic_inst got=%h@%0d want=%h@%0d", o, oc, e, ec);
      end
    end
    checks++;
    if (din_cyc.size() != 32 || done_cyc.size() != 1) begin
      errors++;
      $display("[TB] FAIL basic_beats got=%0d/%0d want=32/1", din_cyc.size(), done_cyc.size());
    end else begin
      first_din = din_cyc[0];
      checks++;
      if (din_cyc[31] - first_din != 31 || done_cyc[0] != din_cyc[31] || first_din != last_data_hs + 1) begin
        errors++;
        $display("[TB] FAIL basic_timing got=first%0d last%0d done%0d want=first%0d last%0d done%0d",
                 first_din, din_cyc[31], done_cyc[0], last_data_hs + 1, last_data_hs + 32, last_data_hs + 32);
      end
    end
    while (data_exp.size() > 0 && data_obs.size() > 0) begin
      logic [DATA_WIDTH*2-1:0] e, o;
      e = data_exp.pop_front(); o = data_obs.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("[TB] FAIL basic_data got=%h want=%h", o, e); end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || overlap_cnt != 0) begin
      errors++;
      $display("[TB] FAIL basic_end got=busy%b overlap%0d want=busy0 overlap0", busy, overlap_cnt);
    end
  endtask

  task automatic test_toggle_no_inst();
    int ni, nd;
    bit seen;
    clear_sb();
    drive_job(1'b1, 5'd0, 0, 32, 64'h0, 32'h1000, 0, 1'b1, 120, ni, nd);
    wait_done(100, seen);
    checks++;
    if (!seen || nd != 32 || inst_obs.size() != 0) begin
      errors++;
      $display("[TB] FAIL toggle_accept got=done%0d data%0d inst%0d want=done1 data32 inst0", seen, nd, inst_obs.size());
    end
    checks++;
    if (din_cyc.size() != 32 || din_cyc[31] - din_cyc[0] != 31 || din_cyc[0] != last_data_hs + 1) begin
      errors++;
      $display("[TB] FAIL toggle_burst got=beats%0d first%0d want=beats32 first%0d contiguous",
               din_cyc.size(), (din_cyc.size() > 0) ? din_cyc[0] : -1, last_data_hs + 1);
    end
    while (data_exp.size() > 0 && data_obs.size() > 0) begin
      logic [DATA_WIDTH*2-1:0] e, o;
      e = data_exp.pop_front(); o = data_obs.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("[TB] FAIL toggle_data got=%h want=%h", o, e); end
    end
  endtask

  task automatic test_overflow_restart();
    int ni, nd;
    bit seen;
    clear_sb();
    drive_job(1'b1, 5'd2, 0, 33, 64'h0, 32'h2000, 0, 1'b0, 45, ni, nd);
    checks++;
    if (nd != 32 || bus.s_data_rdy !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL overflow_full got=data%0d rdy%b busy%b want=data32 rdy0 busy1", nd, bus.s_data_rdy, busy);
    end
    start = 1'b1; inst_len = 5'd0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || bus.s_inst_rdy !== 1'b1 || data_obs.size() != 0) begin
      errors++;
      $display("[TB] FAIL restart_ignored got=busy%b irdy%b beats%0d want=busy1 irdy1 beats0",
               busy, bus.s_inst_rdy, data_obs.size());
    end
    drive_job(1'b0, 5'd0, 2, 0, 64'h50, 32'h0, 0, 1'b0, 20, ni, nd);
    wait_done(100, seen);
    checks++;
    if (!seen || inst_obs.size() != 2 || data_obs.size() != 32) begin
      errors++;
      $display("[TB] FAIL overflow_job got=done%0d inst%0d beats%0d want=done1 inst2 beats32",
               seen, inst_obs.size(), data_obs.size());
    end
    while (data_exp.size() > 0 && data_obs.size() > 0) begin
      logic [DATA_WIDTH*2-1:0] e, o;
      e = data_exp.pop_front(); o = data_obs.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("[TB] FAIL overflow_data got=%h want=%h", o, e); end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL overflow_end_busy got=%b want=0", busy); end
  endtask

  task automatic test_data_first();
    int ni, nd;
    bit seen;
    clear_sb();
    drive_job(1'b1, 5'd4, 4, 32, 64'h70, 32'h3000, 2, 1'b0, 100, ni, nd);
    wait_done(100, seen);
    checks++;
    if (!seen || ni != 4 || nd != 32 || inst_obs_cyc.size() != 4 || din_cyc.size() != 32) begin
      errors++;
      $display("[TB] FAIL dfirst_accept got=done%0d inst%0d data%0d want=done1 inst4 data32", seen, ni, nd);
    end else begin
      checks++;
      if (din_cyc[0] <= inst_obs_cyc[3] || overlap_cnt != 0 || din_cyc[31] - din_cyc[0] != 31) begin
        errors++;
        $display("[TB] FAIL dfirst_order got=first_din%0d last_inst%0d overlap%0d want=first_din>last_inst overlap0",
                 din_cyc[0], inst_obs_cyc[3], overlap_cnt);
      end
    end
    while (inst_exp.size() > 0 && inst_obs.size() > 0) begin
      logic [INST_WIDTH-1:0] e, o;
      e = inst_exp.pop_front(); o = inst_obs.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("[TB] FAIL dfirst_inst got=%h want=%h", o, e); end
    end
    while (data_exp.size() > 0 && data_obs.size() > 0) begin
      logic [DATA_WIDTH*2-1:0] e, o;
      e = data_exp.pop_front(); o = data_obs.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("[TB] FAIL dfirst_data got=%h want=%h", o, e); end
    end
  endtask

  task automatic test_reset_mid_burst();
    int ni, nd;
    bit seen, reached;
    clear_sb();
    drive_job(1'b1, 5'd0, 0, 32, 64'h0, 32'd200, 0, 1'b0, 60, ni, nd);
    reached = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (data_obs.size() >= 10) begin reached = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!reached) begin errors++; $display("[TB] FAIL abort_reach got=%0d beats want=10", data_obs.size()); end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({busy, done, bus.din_v, bus.inst_in_v, bus.s_data_rdy, bus.s_inst_rdy} !== 6'b0
        || bus.din_pe !== '0 || bus.inst_in !== '0) begin
      errors++;
      $display("[TB] FAIL abort_outputs got=%b din=%h want=000000 din=0",
               {busy, done, bus.din_v, bus.inst_in_v, bus.s_data_rdy, bus.s_inst_rdy}, bus.din_pe);
    end
    @(negedge clk);
    rst = 1'b1;
    clear_sb();
    drive_job(1'b1, 5'd0, 0, 32, 64'h0, 32'd100, 0, 1'b0, 60, ni, nd);
    wait_done(100, seen);
    checks++;
    if (!seen || data_obs.size() != 32 || done_cyc.size() != 1) begin
      errors++;
      $display("[TB] FAIL abort_rerun got=done%0d beats%0d want=done1 beats32", done_cyc.size(), data_obs.size());
    end
    for (int i = 0; i < 32 && data_obs.size() > 0; i++) begin
      logic [DATA_WIDTH*2-1:0] o;
      o = data_obs.pop_front();
      checks++;
      if (o !== (DATA_WIDTH*2)'(100 + i)) begin
        errors++;
        $display("[TB] FAIL abort_data got=%0d want=%0d", o, 100 + i);
      end
    end
  endtask

  task automatic test_saturate();
    int ni, nd;
    bit seen;
    clear_sb();
    drive_job(1'b1, 5'd20, 20, 32, 64'h100, 32'h4000, 0, 1'b0, 90, ni, nd);
    wait_done(100, seen);
    checks++;
    if (!seen || ni != 16 || inst_obs.size() != 16 || nd != 32) begin
      errors++;
      $display("[TB] FAIL sat_count got=done%0d acc%0d beats%0d data%0d want=done1 acc16 beats16 data32",
               seen, ni, inst_obs.size(), nd);
    end
    while (inst_exp.size() > 0 && inst_obs.size() > 0) begin
      logic [INST_WIDTH-1:0] e, o;
      e = inst_exp.pop_front(); o = inst_obs.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("[TB] FAIL sat_inst got=%h want=%h", o, e); end
    end
    while (data_exp.size() > 0 && data_obs.size() > 0) begin
      logic [DATA_WIDTH*2-1:0] e, o;
      e = data_exp.pop_front(); o = data_obs.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("[TB] FAIL sat_data got=%h want=%h", o, e); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_toggle_no_inst();
    test_overflow_restart();
    test_data_first();
    test_reset_mid_burst();
    test_saturate();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
